// File: rtl/frame_buffer_ovl.sv
`default_nettype none
// ============================================================================
// Module   : frame_buffer_ovl
// Brief    : Overlapping frame collector for the FFT input. Real samples enter
//            a circular store and leave as packed {sample, 0} complex frames
//            with valid/ready handshakes on both sides.
// Revision : 1.0 - initial release
// ============================================================================
module frame_buffer_ovl #(
  parameter int DATA_W    = 16,
  parameter int FRAME_LEN = 16,
  parameter int HOP       = 16,
  parameter int CNT_W     = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          data_valid_i,
  input  logic [DATA_W-1:0]             data,
  output logic                          data_ready_o,
  input  logic                          flush,
  output logic [FRAME_LEN*2*DATA_W-1:0] x,
  output logic                          data_valid_o,
  input  logic                          data_ready_i,
  output logic [CNT_W-1:0]              frame_cnt
);

  localparam int c_PTR_W  = $clog2(FRAME_LEN);
  localparam int c_SUM_W  = c_PTR_W + 1;
  localparam int c_FILL_W = $clog2(FRAME_LEN + 1);
  localparam int c_HOP_W  = (HOP > 1) ? $clog2(HOP) : 1;

  localparam logic [c_PTR_W-1:0]  c_PTR_LAST  = c_PTR_W'(FRAME_LEN - 1);
  localparam logic [c_SUM_W-1:0]  c_SUM_LEN   = c_SUM_W'(FRAME_LEN);
  localparam logic [c_FILL_W-1:0] c_FILL_FULL = c_FILL_W'(FRAME_LEN);
  localparam logic [c_FILL_W-1:0] c_FILL_LAST = c_FILL_W'(FRAME_LEN - 1);
  localparam logic [c_HOP_W-1:0]  c_HOP_LAST  = c_HOP_W'(HOP - 1);

  logic [DATA_W-1:0]             r_mem [FRAME_LEN];
  logic [c_PTR_W-1:0]            r_wr_ptr;
  logic [c_FILL_W-1:0]           r_fill;
  logic [c_HOP_W-1:0]            r_hop_cnt;
  logic                          w_would_complete;
  logic                          w_accept;
  logic                          w_complete;
  logic [FRAME_LEN*2*DATA_W-1:0] w_frame;

  assign w_would_complete = (r_fill == c_FILL_LAST) ||
                            ((r_fill == c_FILL_FULL) && (r_hop_cnt == c_HOP_LAST));

  // Stall only the sample that would need the output register while it is still occupied.
  assign data_ready_o = !(data_valid_o && !data_ready_i && w_would_complete);
  assign w_accept     = data_valid_i && data_ready_o && !flush;
  assign w_complete   = w_accept && w_would_complete;

  // Oldest stored sample sits just after the write pointer; the newest is the incoming one.
  generate
    for (genvar k = 0; k < FRAME_LEN; k++) begin : g_snap
      if (k == FRAME_LEN - 1) begin : g_newest
        assign w_frame[k*2*DATA_W +: 2*DATA_W] = {data, {DATA_W{1'b0}}};
      end else begin : g_stored
        logic [c_SUM_W-1:0] w_sum;
        logic [c_PTR_W-1:0] w_idx;
        assign w_sum = {1'b0, r_wr_ptr} + c_SUM_W'(k + 1);
        assign w_idx = (w_sum >= c_SUM_LEN) ? c_PTR_W'(w_sum - c_SUM_LEN)
                                            : w_sum[c_PTR_W-1:0];
        assign w_frame[k*2*DATA_W +: 2*DATA_W] = {r_mem[w_idx], {DATA_W{1'b0}}};
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_mem[r_wr_ptr] <= data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr  <= '0;
      r_fill    <= '0;
      r_hop_cnt <= '0;
    end else if (flush) begin
      r_wr_ptr  <= '0;
      r_fill    <= '0;
      r_hop_cnt <= '0;
    end else if (w_accept) begin
      r_wr_ptr <= (r_wr_ptr == c_PTR_LAST) ? '0 : r_wr_ptr + c_PTR_W'(1);
      if (r_fill != c_FILL_FULL) begin
        r_fill <= r_fill + c_FILL_W'(1);
      end
      if (w_complete) begin
        r_hop_cnt <= '0;
      end else if (r_fill == c_FILL_FULL) begin
        r_hop_cnt <= r_hop_cnt + c_HOP_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x            <= '0;
      data_valid_o <= 1'b0;
      frame_cnt    <= '0;
    end else if (w_complete) begin
      x            <= w_frame;
      data_valid_o <= 1'b1;
      frame_cnt    <= frame_cnt + CNT_W'(1);
    end else if (data_valid_o && data_ready_i) begin
      data_valid_o <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_frame_buffer_ovl.sv
`default_nettype none
// ============================================================================
// Module   : tb_frame_buffer_ovl
// Brief    : Self-checking bench for frame_buffer_ovl against a sample-history
//            reference model (FRAME_LEN=4, HOP=2, CNT_W=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_frame_buffer_ovl;

  localparam int DATA_W    = 16;
  localparam int FRAME_LEN = 4;
  localparam int HOP       = 2;
  localparam int CNT_W     = 2;
  localparam int XW        = FRAME_LEN * 2 * DATA_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              data_valid_i;
  logic [DATA_W-1:0] data;
  logic              data_ready_o;
  logic              flush;
  logic [XW-1:0]     x;
  logic              data_valid_o;
  logic              data_ready_i;
  logic [CNT_W-1:0]  frame_cnt;

  always #5 clk = ~clk;

  frame_buffer_ovl #(
    .DATA_W(DATA_W), .FRAME_LEN(FRAME_LEN), .HOP(HOP), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .data_valid_i(data_valid_i), .data(data),
    .data_ready_o(data_ready_o), .flush(flush), .x(x),
    .data_valid_o(data_valid_o), .data_ready_i(data_ready_i), .frame_cnt(frame_cnt)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: samples accepted since the last flush/reset, and the held frame.
  int                n_acc;
  logic [DATA_W-1:0] hist[$];
  logic [DATA_W-1:0] exp_frame [FRAME_LEN];
  bit                exp_valid;
  int                exp_cnt;

  function automatic bit completes_at(int n);
    return (n >= FRAME_LEN) && (((n - FRAME_LEN) % HOP) == 0);
  endfunction

  function automatic bit exp_ready();
    return !(exp_valid && !data_ready_i && completes_at(n_acc + 1));
  endfunction

  function automatic logic [XW-1:0] exp_x();
    logic [XW-1:0] v;
    v = '0;
    for (int k = 0; k < FRAME_LEN; k++) v[k*2*DATA_W + DATA_W +: DATA_W] = exp_frame[k];
    return v;
  endfunction

  task automatic model_reset();
    n_acc = 0;
    hist.delete();
    exp_valid = 1'b0;
    exp_cnt = 0;
    for (int k = 0; k < FRAME_LEN; k++) exp_frame[k] = '0;
  endtask

  // Advance the model by one edge using the currently driven inputs, then clock the DUT.
  task automatic tick();
    bit acc;
    bit done;
    acc  = !flush && data_valid_i && exp_ready();
    done = 1'b0;
    if (flush) begin
      n_acc = 0;
      hist.delete();
    end else if (acc) begin
      hist.push_back(data);
      if (hist.size() > FRAME_LEN) void'(hist.pop_front());
      n_acc++;
      done = completes_at(n_acc);
    end
    if (done) begin
      for (int k = 0; k < FRAME_LEN; k++) exp_frame[k] = hist[k];
      exp_valid = 1'b1;
      exp_cnt = (exp_cnt + 1) % (1 << CNT_W);
    end else if (exp_valid && data_ready_i) begin
      exp_valid = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; data_valid_i = 1'b0; data = '0; flush = 1'b0; data_ready_i = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (data_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", data_valid_o); end
    checks++;
    if (x !== '0) begin errors++; $display("FAIL reset_x: got %h expected 0", x); end
    checks++;
    if (frame_cnt !== '0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", frame_cnt); end
    rst = 1'b1;
    #1;
    checks++;
    if (data_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", data_ready_o); end
  endtask

  task automatic test_overlap();
    logic [XW-1:0] first;
    first = {16'd4, 16'd0, 16'd3, 16'd0, 16'd2, 16'd0, 16'd1, 16'd0};
    data_ready_i = 1'b1;
    for (int s = 1; s <= 9; s++) begin
      data_valid_i = (s <= 8);
      data = DATA_W'(s);
      tick();
      checks++;
      if (data_valid_o !== exp_valid) begin errors++; $display("FAIL ovl_valid s=%0d: got %b expected %b", s, data_valid_o, exp_valid); end
      if (exp_valid) begin
        checks++;
        if (x !== exp_x()) begin errors++; $display("FAIL ovl_x s=%0d: got %h expected %h", s, x, exp_x()); end
      end
      checks++;
      if (frame_cnt !== CNT_W'(exp_cnt)) begin errors++; $display("FAIL ovl_cnt s=%0d: got %0d expected %0d", s, frame_cnt, exp_cnt); end
      if (s == 4) begin
        checks++;
        if (x !== first) begin errors++; $display("FAIL ovl_first: got %h expected %h", x, first); end
      end
    end
    checks++;
    if (frame_cnt !== 2'd3) begin errors++; $display("FAIL ovl_total: got %0d expected 3", frame_cnt); end
  endtask

  task automatic test_backpressure();
    int s;
    bit acc;
    logic [XW-1:0] held;
    data_valid_i = 1'b0; flush = 1'b1; data_ready_i = 1'b1;
    tick();
    flush = 1'b0;
    s = 1;
    for (int cyc = 0; cyc < 12; cyc++) begin
      data_ready_i = (cyc >= 9);
      data_valid_i = 1'b1;
      data = DATA_W'(s);
      #1;
      checks++;
      if (data_ready_o !== exp_ready()) begin errors++; $display("FAIL bp_ready cyc=%0d: got %b expected %b", cyc, data_ready_o, exp_ready()); end
      if (cyc == 6) begin
        checks++;
        if (data_ready_o !== 1'b0) begin errors++; $display("FAIL bp_stall: got %b expected 0", data_ready_o); end
      end
      acc = exp_ready();
      tick();
      if (acc) s++;
      checks++;
      if (data_valid_o !== exp_valid) begin errors++; $display("FAIL bp_valid cyc=%0d: got %b expected %b", cyc, data_valid_o, exp_valid); end
      if (exp_valid) begin
        checks++;
        if (x !== exp_x()) begin errors++; $display("FAIL bp_x cyc=%0d: got %h expected %h", cyc, x, exp_x()); end
      end
      if (cyc == 3) held = x;
      if (cyc == 8) begin
        checks++;
        if (x !== held) begin errors++; $display("FAIL bp_hold: got %h expected %h", x, held); end
      end
      if (cyc == 9) begin
        checks++;
        if (data_valid_o !== 1'b1) begin errors++; $display("FAIL bp_reload_valid: got %b expected 1", data_valid_o); end
      end
    end
    data_valid_i = 1'b0;
  endtask

  task automatic test_flush();
    logic [XW-1:0] want;
    int vals[7];
    vals = '{1, 2, -1, 10, 11, 12, 13};
    want = {16'd13, 16'd0, 16'd12, 16'd0, 16'd11, 16'd0, 16'd10, 16'd0};
    data_ready_i = 1'b1; data_valid_i = 1'b0; flush = 1'b1;
    tick();
    for (int i = 0; i < 7; i++) begin
      flush = (vals[i] < 0);
      data_valid_i = 1'b1;
      data = DATA_W'(vals[i] < 0 ? 99 : vals[i]);
      tick();
      checks++;
      if (data_valid_o !== exp_valid) begin errors++; $display("FAIL flush_valid i=%0d: got %b expected %b", i, data_valid_o, exp_valid); end
    end
    flush = 1'b0; data_valid_i = 1'b0;
    checks++;
    if (x !== want) begin errors++; $display("FAIL flush_x: got %h expected %h", x, want); end
  endtask

  task automatic test_async_reset();
    logic [XW-1:0] want;
    want = {16'd24, 16'd0, 16'd23, 16'd0, 16'd22, 16'd0, 16'd21, 16'd0};
    data_ready_i = 1'b0; flush = 1'b1; data_valid_i = 1'b0;
    tick();
    flush = 1'b0;
    for (int s = 1; s <= 7; s++) begin
      data_valid_i = 1'b1;
      data = DATA_W'(s);
      tick();
    end
    data_valid_i = 1'b0;
    checks++;
    if (data_valid_o !== 1'b1) begin errors++; $display("FAIL ar_pending: got %b expected 1", data_valid_o); end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (data_valid_o !== 1'b0) begin errors++; $display("FAIL ar_valid: got %b expected 0", data_valid_o); end
    checks++;
    if (x !== '0) begin errors++; $display("FAIL ar_x: got %h expected 0", x); end
    checks++;
    if (frame_cnt !== '0) begin errors++; $display("FAIL ar_cnt: got %0d expected 0", frame_cnt); end
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    data_ready_i = 1'b1;
    for (int s = 21; s <= 24; s++) begin
      data_valid_i = 1'b1;
      data = DATA_W'(s);
      tick();
      checks++;
      if (data_valid_o !== (s == 24)) begin errors++; $display("FAIL ar_refill s=%0d: got %b expected %b", s, data_valid_o, (s == 24)); end
    end
    data_valid_i = 1'b0;
    checks++;
    if (x !== want) begin errors++; $display("FAIL ar_frame: got %h expected %h", x, want); end
  endtask

  task automatic test_cnt_wrap();
    int seen [5];
    int want [5];
    int n_seen;
    want = '{1, 2, 3, 0, 1};
    n_seen = 0;
    rst = 1'b0; data_valid_i = 1'b0; flush = 1'b0; data_ready_i = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int cyc = 0; cyc < 40 && n_seen < 5; cyc++) begin
      data_valid_i = 1'b1;
      data = DATA_W'(100 + cyc);
      tick();
      checks++;
      if (data_valid_o !== exp_valid) begin errors++; $display("FAIL wrap_valid cyc=%0d: got %b expected %b", cyc, data_valid_o, exp_valid); end
      if (data_valid_o) begin
        seen[n_seen] = int'(frame_cnt);
        n_seen++;
      end
    end
    data_valid_i = 1'b0;
    checks++;
    if (n_seen != 5) begin
      errors++; $display("FAIL wrap_frames: got %0d frames expected 5", n_seen);
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (seen[i] != want[i]) begin errors++; $display("FAIL wrap_cnt[%0d]: got %0d expected %0d", i, seen[i], want[i]); end
      end
    end
  endtask

  task automatic test_random();
    for (int cyc = 0; cyc < 500; cyc++) begin
      data_valid_i = ($urandom_range(0, 3) != 0);
      data_ready_i = ($urandom_range(0, 2) != 0);
      flush        = ($urandom_range(0, 40) == 0);
      data         = DATA_W'($urandom());
      #1;
      checks++;
      if (data_ready_o !== exp_ready()) begin errors++; $display("FAIL rnd_ready cyc=%0d: got %b expected %b", cyc, data_ready_o, exp_ready()); end
      tick();
      checks++;
      if (data_valid_o !== exp_valid) begin errors++; $display("FAIL rnd_valid cyc=%0d: got %b expected %b", cyc, data_valid_o, exp_valid); end
      if (exp_valid) begin
        checks++;
        if (x !== exp_x()) begin errors++; $display("FAIL rnd_x cyc=%0d: got %h expected %h", cyc, x, exp_x()); end
      end
      checks++;
      if (frame_cnt !== CNT_W'(exp_cnt)) begin errors++; $display("FAIL rnd_cnt cyc=%0d: got %0d expected %0d", cyc, frame_cnt, exp_cnt); end
    end
    data_valid_i = 1'b0; flush = 1'b0;
  endtask

  initial begin
    test_reset();
    test_overlap();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_cnt_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
